mmio_sim_ctrl: RTL and testbench

- Synthesizable memory-mapped simulation-control device on the core_top DCCM write port.
- Decodes stores to the console and finish addresses; buffers console bytes in a FIFO drained over a valid/ready stream; latches the finish exit code.
- Runs a no-retire watchdog, so benches and FPGA builds get console, finish and hang detection from RTL instead of hierarchical probes.

---
 rtl/mmio_sim_pkg.sv | 20 ++
 rtl/mmio_sim_ctrl_if.sv | 46 ++++
 rtl/mmio_sim_ctrl_fifo.sv | 49 ++++
 rtl/mmio_sim_ctrl.sv | 106 ++++++++++
 tb/tb_mmio_sim_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_sim_pkg.sv
// Shared constants and types for the mmio_sim_ctrl simulation-control device.
package mmio_sim_pkg;

    localparam int XLEN               = 32;
    localparam int FIFO_DEPTH_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 1000;

    localparam logic [XLEN-1:0] CONSOLE_ADDR_DEF = 32'h0020_0000;
    localparam logic [XLEN-1:0] FINISH_ADDR_DEF  = 32'h1000_0000;

    typedef logic [7:0] cons_byte_t;

    // Watchdog width: wide enough to hold TIMEOUT_CYCLES-1 for any timeout value.
    function automatic int wdog_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    localparam int WDOG_W = wdog_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/mmio_sim_ctrl_if.sv
// Bus bundle for mmio_sim_ctrl: DCCM write port, retire pulse, console stream, status.
// Optional cycle counters are present when MMIO_SIM_CYCLE_CNT_EN is defined.
interface mmio_sim_ctrl_if
    import mmio_sim_pkg::*;
#(
    parameter int XLEN_P     = XLEN,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              dccm_wen;
    logic [XLEN_P-1:0] dccm_waddr;
    logic [XLEN_P-1:0] dccm_wdata;
    logic              retire_valid;
    logic              cons_valid;
    cons_byte_t        cons_data;
    logic              cons_ready;
    logic [LVL_W-1:0]  cons_level;
    logic              cons_overflow;
    logic              finish;
    logic [XLEN_P-1:0] exit_code;
    logic              timeout;
`ifdef MMIO_SIM_CYCLE_CNT_EN
    logic [63:0]       cycle_count;
    logic [63:0]       cycles_at_finish;
`endif

    modport slave (
        input  dccm_wen, dccm_waddr, dccm_wdata, retire_valid, cons_ready,
        output cons_valid, cons_data, cons_level, cons_overflow,
        output finish, exit_code, timeout
`ifdef MMIO_SIM_CYCLE_CNT_EN
        , output cycle_count, cycles_at_finish
`endif
    );

    modport master (
        output dccm_wen, dccm_waddr, dccm_wdata, retire_valid, cons_ready,
        input  cons_valid, cons_data, cons_level, cons_overflow,
        input  finish, exit_code, timeout
`ifdef MMIO_SIM_CYCLE_CNT_EN
        , input cycle_count, cycles_at_finish
`endif
    );

endinterface

// File: rtl/mmio_sim_ctrl_fifo.sv
// Synchronous FIFO with registered head (no fall-through) and extra-MSB pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately not reset; resetting the pointers empties the FIFO.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_sim_ctrl.sv
// Memory-mapped simulation control: console FIFO, finish/exit-code latch, no-retire watchdog.
// Define MMIO_SIM_CYCLE_CNT_EN to add cycle_count / cycles_at_finish outputs.
module mmio_sim_ctrl
    import mmio_sim_pkg::*;
#(
    parameter logic [XLEN-1:0] CONSOLE_ADDR   = CONSOLE_ADDR_DEF,
    parameter logic [XLEN-1:0] FINISH_ADDR    = FINISH_ADDR_DEF,
    parameter int              FIFO_DEPTH     = FIFO_DEPTH_DEF,
    parameter int              TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mmio_sim_ctrl_if.slave bus
);
    localparam int WD_W = wdog_width(TIMEOUT_CYCLES);

    logic            r_finish;
    logic            r_timeout;
    logic            r_overflow;
    logic [XLEN-1:0] r_exit_code;
    logic [WD_W-1:0] r_wdog;

    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_finish_set;
    logic       w_timeout_set;
    cons_byte_t w_head;

    assign w_push = bus.dccm_wen && (bus.dccm_waddr == CONSOLE_ADDR) && !r_finish;
    assign w_pop  = bus.cons_ready && !w_empty;

    // Finish has priority over a coincident watchdog expiry; the two flags never both set.
    assign w_finish_set  = bus.dccm_wen && (bus.dccm_waddr == FINISH_ADDR) &&
                           !r_finish && !r_timeout;
    assign w_timeout_set = !r_finish && !r_timeout && !bus.retire_valid &&
                           (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) && !w_finish_set;

    sync_fifo #(
        .WIDTH ($bits(cons_byte_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.dccm_wdata[7:0]),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (bus.cons_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_finish    <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_exit_code <= '0;
        end else begin
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_timeout_set) r_timeout <= 1'b1;
            if (w_finish_set) begin
                r_finish    <= 1'b1;
                r_exit_code <= bus.dccm_wdata;
            end
        end
    end

    // Counter stops at TIMEOUT_CYCLES-1 when it expires; the sticky flags then gate it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (!r_finish && !r_timeout) begin
            if (bus.retire_valid)                          r_wdog <= '0;
            else if (r_wdog != WD_W'(TIMEOUT_CYCLES - 1))  r_wdog <= r_wdog + 1'b1;
        end
    end

`ifdef MMIO_SIM_CYCLE_CNT_EN
    logic [63:0] r_cycle_count;
    logic [63:0] r_cycles_at_finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_count      <= '0;
            r_cycles_at_finish <= '0;
        end else begin
            if (!r_finish && !r_timeout) r_cycle_count <= r_cycle_count + 64'd1;
            if (w_finish_set || w_timeout_set) r_cycles_at_finish <= r_cycle_count;
        end
    end

    assign bus.cycle_count      = r_cycle_count;
    assign bus.cycles_at_finish = r_cycles_at_finish;
`endif

    assign bus.cons_valid    = !w_empty;
    assign bus.cons_data     = w_head;
    assign bus.cons_overflow = r_overflow;
    assign bus.finish        = r_finish;
    assign bus.exit_code     = r_exit_code;
    assign bus.timeout       = r_timeout;

endmodule

// File: tb/tb_mmio_sim_ctrl.sv
// Self-checking bench for mmio_sim_ctrl: directed steps plus a random console phase
// compared against a queue-based reference model.
module tb_mmio_sim_ctrl;
    import mmio_sim_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_sim_ctrl_if #(.XLEN_P(XLEN), .FIFO_DEPTH(DEPTH)) bus ();

    mmio_sim_ctrl #(
        .CONSOLE_ADDR   (CONSOLE_ADDR_DEF),
        .FINISH_ADDR    (FINISH_ADDR_DEF),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: console bytes in a queue, plus the sticky flags.
    cons_byte_t  m_q[$];
    logic        m_ovf;
    logic        m_finish;
    logic [31:0] m_exit;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ovf    = 1'b0;
        m_finish = 1'b0;
        m_exit   = '0;
    endtask

    // Advance one clock; the model consumes the inputs that the DUT samples at this edge.
    task automatic tick();
        bit pop_req, push_req, fin_req;
        cons_byte_t b;
        pop_req  = bus.cons_ready && (m_q.size() > 0);
        push_req = bus.dccm_wen && bus.dccm_waddr == CONSOLE_ADDR_DEF && !m_finish;
        fin_req  = bus.dccm_wen && bus.dccm_waddr == FINISH_ADDR_DEF && !m_finish;
        b = bus.dccm_wdata[7:0];
        @(posedge clk);
        #1;
        if (pop_req) void'(m_q.pop_front());
        if (push_req) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else m_ovf = 1'b1;
        end
        if (fin_req) begin
            m_finish = 1'b1;
            m_exit   = bus.dccm_wdata;
        end
    endtask

    task automatic check_cons(input string tag);
        check({tag, "_valid"}, bus.cons_valid, m_q.size() > 0);
        check({tag, "_level"}, bus.cons_level, m_q.size());
        check({tag, "_ovf"}, bus.cons_overflow, m_ovf);
        if (m_q.size() > 0) check({tag, "_data"}, bus.cons_data, m_q[0]);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.dccm_wen   = 1'b1;
        bus.dccm_waddr = addr;
        bus.dccm_wdata = data;
        tick();
        bus.dccm_wen = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_valid"}, bus.cons_valid, 1'b0);
        check({tag, "_data"}, bus.cons_data, 8'h00);
        check({tag, "_level"}, bus.cons_level, 0);
        check({tag, "_ovf"}, bus.cons_overflow, 1'b0);
        check({tag, "_finish"}, bus.finish, 1'b0);
        check({tag, "_exit"}, bus.exit_code, 0);
        check({tag, "_timeout"}, bus.timeout, 1'b0);
`ifdef MMIO_SIM_CYCLE_CNT_EN
        check({tag, "_cycles"}, bus.cycle_count, 0);
        check({tag, "_cyc_fin"}, bus.cycles_at_finish, 0);
`endif
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cons_byte_t  last;
        logic [31:0] addr;
        int          n;

        bus.dccm_wen     = 1'b0;
        bus.dccm_waddr   = '0;
        bus.dccm_wdata   = '0;
        bus.cons_ready   = 1'b0;
        bus.retire_valid = 1'b1;
        model_clear();

        apply_reset("por");

        // "Hi" with the sink always ready; first push into an empty FIFO must not fall through.
        bus.cons_ready = 1'b1;
        bus.dccm_wen   = 1'b1;
        bus.dccm_waddr = CONSOLE_ADDR_DEF;
        bus.dccm_wdata = 32'h48;
        #1;
        check("no_fallthrough", bus.cons_valid, 1'b0);
        tick();
        check("hi_H", bus.cons_data, 8'h48);
        check_cons("hi1");
        bus.dccm_wdata = 32'h69;
        tick();
        bus.dccm_wen = 1'b0;
        check("hi_i", bus.cons_data, 8'h69);
        check_cons("hi2");
        tick();
        check("hi_level0", bus.cons_level, 0);
        check_cons("hi3");

        // Seventeen pushes into a stalled sink: the last one is dropped.
        bus.cons_ready = 1'b0;
        for (int i = 0; i < 17; i++) store(CONSOLE_ADDR_DEF, i);
        check("ovf_level", bus.cons_level, 16);
        check("ovf_flag", bus.cons_overflow, 1'b1);
        tick();
        check("ovf_stable", bus.cons_data, 8'h00);
        bus.cons_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain", bus.cons_data, i);
            tick();
        end
        check("ovf_empty_level", bus.cons_level, 0);
        check("ovf_empty_valid", bus.cons_valid, 1'b0);
        bus.cons_ready = 1'b0;

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 16; i++) store(CONSOLE_ADDR_DEF, $urandom);
        check("fpp_full", bus.cons_level, 16);
        bus.cons_ready = 1'b1;
        store(CONSOLE_ADDR_DEF, 32'hEE);
        check("fpp_level", bus.cons_level, 16);
        check_cons("fpp");
        last = '0;
        for (int i = 0; i < 16; i++) begin
            last = bus.cons_data;
            check_cons("fpp_drain");
            tick();
        end
        check("fpp_last", last, 8'hEE);
        check_cons("fpp_end");

        // Random console traffic with stray stores to other addresses.
        for (int i = 0; i < 400; i++) begin
            addr = ($urandom_range(0, 3) == 0) ? $urandom : CONSOLE_ADDR_DEF;
            if (addr == FINISH_ADDR_DEF) addr = 32'h0;
            bus.dccm_wen   = ($urandom_range(0, 1) == 1);
            bus.dccm_waddr = addr;
            bus.dccm_wdata = $urandom;
            bus.cons_ready = ($urandom_range(0, 9) < 4);
            tick();
            check_cons("rand");
        end
        bus.dccm_wen   = 1'b0;
        bus.cons_ready = 1'b1;
        for (int i = 0; i < 40 && m_q.size() > 0; i++) begin
            tick();
            check_cons("rand_drain");
        end
        check("rand_drained", bus.cons_level, 0);

        // Finish: first store wins, console stores then ignored, draining continues.
        bus.cons_ready = 1'b0;
        for (int i = 0; i < 7; i++) store(CONSOLE_ADDR_DEF, 8'h30 + i);
        store(FINISH_ADDR_DEF, 32'h0000_002A);
        check("fin_flag", bus.finish, 1'b1);
        check("fin_exit", bus.exit_code, 32'h2A);
        store(FINISH_ADDR_DEF, 32'h5);
        check("fin_first_wins", bus.exit_code, 32'h2A);
        store(CONSOLE_ADDR_DEF, 32'h77);
        check("fin_cons_ignored", bus.cons_level, 7);
        bus.cons_ready = 1'b1;
        tick();
        tick();
        bus.cons_ready = 1'b0;
        check("fin_drain_data", bus.cons_data, 8'h32);
        check_cons("fin_drain");
        bus.retire_valid = 1'b0;
        repeat (1100) tick();
        check("fin_wdog_frozen", bus.timeout, 1'b0);
        check("fin_level5", bus.cons_level, 5);
        check("fin_still", bus.finish, 1'b1);

        // Asynchronous reset mid-operation, away from the clock edge.
        #2;
        apply_reset("mid_rst");
        bus.retire_valid = 1'b1;
        store(CONSOLE_ADDR_DEF, 32'hA5);
        check("post_rst_data", bus.cons_data, 8'hA5);
        check_cons("post_rst");

        // Watchdog latency measured from the last retire edge.
        apply_reset("wd_rst1");
        bus.retire_valid = 1'b1;
        tick();
        bus.retire_valid = 1'b0;
        n = 0;
        while (bus.timeout !== 1'b1 && n < 2 * TMO) begin
            tick();
            n++;
        end
        check("wdog_latency", n, TMO);
        check("wdog_no_finish", bus.finish, 1'b0);
        repeat (5) tick();
        check("wdog_sticky", bus.timeout, 1'b1);

        // A retire on the 999th idle cycle restarts the count.
        apply_reset("wd_rst2");
        bus.retire_valid = 1'b1;
        tick();
        bus.retire_valid = 1'b0;
        repeat (TMO - 2) tick();
        bus.retire_valid = 1'b1;
        tick();
        bus.retire_valid = 1'b0;
        repeat (TMO - 1) tick();
        check("wdog_retire999", bus.timeout, 1'b0);
        tick();
        check("wdog_rearmed", bus.timeout, 1'b1);

        // Finish and watchdog expiry on the same edge: finish wins.
        apply_reset("wd_rst3");
        bus.retire_valid = 1'b1;
        tick();
        bus.retire_valid = 1'b0;
        repeat (TMO - 1) tick();
        store(FINISH_ADDR_DEF, 32'h77);
        check("tie_finish", bus.finish, 1'b1);
        check("tie_exit", bus.exit_code, 32'h77);
        check("tie_timeout", bus.timeout, 1'b0);
        repeat (10) tick();
        check("tie_timeout_late", bus.timeout, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
